// File: rtl/video2ram_if.sv
// Pixel-stream and RAM-write bundle between the video capture block and its environment.
// The master side is the capture block: it consumes video/sync and drives the RAM write port.
interface video2ram_if;
  logic [23:0] video_in;
  logic        hsync_in;
  logic        vsync_in;
  logic [13:0] wraddr;
  logic [23:0] wrdata;
  logic        wren;

  modport master (input video_in, hsync_in, vsync_in, output wraddr, wrdata, wren);
  modport slave  (output video_in, hsync_in, vsync_in, input wraddr, wrdata, wren);
endinterface

// File: rtl/video2ram.sv
// Captures a windowed region of the digital video stream into a ring-organised line buffer,
// recovering X/Y from sync edges and raising a sticky start request once the source is locked.
module video2ram #(
  parameter int H_CAPTURE_START    = 128,
  parameter int H_CAPTURE_END      = 768,
  parameter int V_CAPTURE_START    = 36,
  parameter int V_CAPTURE_END      = 516,
  parameter int BUFFER_LINE_LENGTH = 640,
  parameter int RAM_NUMWORDS       = 15360,
  parameter int TRIGGER_LINE       = 2
) (
  input  logic        clock,
  input  logic        reset,
  video2ram_if.master bus,
  output logic        field,
  output logic        locked,
  output logic        starttrigger
);
  localparam logic [11:0] H_START  = 12'(H_CAPTURE_START);
  localparam logic [11:0] H_END    = 12'(H_CAPTURE_END);
  localparam logic [11:0] V_START  = 12'(V_CAPTURE_START);
  localparam logic [11:0] V_END    = 12'(V_CAPTURE_END);
  localparam logic [11:0] TRIG_Y   = 12'(V_CAPTURE_START + TRIGGER_LINE);
  localparam logic [13:0] LINE_LEN = 14'(BUFFER_LINE_LENGTH);
  localparam logic [14:0] WRAP_AT  = 15'(RAM_NUMWORDS - BUFFER_LINE_LENGTH + 1);

  logic [23:0] pix1;
  logic        hs1, vs1, hs2, vs2;
  logic [11:0] x, y, x_len;
  logic [13:0] addr_x, addr_y;
  logic        vs_pending, y_sync;
  logic [1:0]  vs_count;

  logic        hs_fall, vs_fall, y_clear, capture;
  logic [11:0] x_cur, y_cur;
  logic [13:0] addr_x_use, addr_y_cur;
  logic [14:0] addr_y_inc;
  logic [1:0]  vs_count_nxt;

  // x_cur/y_cur are the coordinates of the pixel currently held in stage 1.
  always_comb begin
    hs_fall = hs2 & ~hs1;
    vs_fall = vs2 & ~vs1;
    y_clear = hs_fall & (vs_pending | vs_fall);

    if (hs_fall)            x_cur = 12'd0;
    else if (x == 12'hFFF)  x_cur = x;
    else                    x_cur = x + 12'd1;

    // Y only counts once a vsync has anchored it, so a reset mid-frame never captures garbage lines.
    y_cur = y;
    if (y_clear)                                  y_cur = 12'd0;
    else if (hs_fall && y_sync && y != 12'hFFF)   y_cur = y + 12'd1;

    addr_y_inc = {1'b0, addr_y} + {1'b0, LINE_LEN};
    addr_y_cur = addr_y;
    if (y_clear)
      addr_y_cur = 14'd0;
    else if (hs_fall && y >= V_START && y < V_END)
      addr_y_cur = (addr_y_inc >= WRAP_AT) ? 14'd0 : addr_y_inc[13:0];

    addr_x_use = hs_fall ? 14'd0 : addr_x;
    capture = (x_cur >= H_START) && (x_cur < H_END) && (y_cur >= V_START) && (y_cur < V_END);

    vs_count_nxt = (vs_fall && vs_count != 2'd2) ? vs_count + 2'd1 : vs_count;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pix1         <= 24'd0;
      hs1          <= 1'b1;
      vs1          <= 1'b1;
      hs2          <= 1'b1;
      vs2          <= 1'b1;
      x            <= 12'd0;
      y            <= 12'd0;
      x_len        <= 12'd0;
      addr_x       <= 14'd0;
      addr_y       <= 14'd0;
      vs_pending   <= 1'b0;
      y_sync       <= 1'b0;
      vs_count     <= 2'd0;
      field        <= 1'b0;
      locked       <= 1'b0;
      starttrigger <= 1'b0;
      bus.wren     <= 1'b0;
      bus.wraddr   <= 14'd0;
      bus.wrdata   <= 24'd0;
    end else begin
      pix1 <= bus.video_in;
      hs1  <= bus.hsync_in;
      vs1  <= bus.vsync_in;
      hs2  <= hs1;
      vs2  <= vs1;

      x      <= x_cur;
      y      <= y_cur;
      addr_y <= addr_y_cur;
      if (hs_fall) x_len <= x;

      // A vsync edge coinciding with an hsync edge is consumed on that same edge via y_clear.
      if (hs_fall)      vs_pending <= 1'b0;
      else if (vs_fall) vs_pending <= 1'b1;
      if (y_clear)      y_sync     <= 1'b1;

      if (vs_fall) field <= (x_cur >= (x_len >> 1));

      vs_count <= vs_count_nxt;
      locked   <= (vs_count_nxt == 2'd2);
      if (hs_fall && locked && y_cur == TRIG_Y) starttrigger <= 1'b1;

      if (capture)                          addr_x <= addr_x_use + 14'd1;
      else if (hs_fall || x_cur < H_START)  addr_x <= 14'd0;

      bus.wren <= capture;
      if (capture) begin
        bus.wraddr <= addr_y_cur + addr_x_use;
        bus.wrdata <= pix1;
      end
    end
  end
endmodule
